// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop requests, RAM drive and status flags of the FIFO controller
interface fifo_ctrl_if #(parameter int ADDR_WIDTH = 3);
    logic                  wr;
    logic                  rd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_err;
    logic                  rd_err;
    modport master (output wr, rd,
                    input  we, w_addr, r_addr, full, empty, almost_full, almost_empty, count, wr_err, rd_err);
    modport slave  (input  wr, rd,
                    output we, w_addr, r_addr, full, empty, almost_full, almost_empty, count, wr_err, rd_err);
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller driving a show-ahead synchronous FIFO RAM
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input logic       clk,
    input logic       reset_n,
    fifo_ctrl_if.slave bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
    logic [AW:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count_q, count_d;
    logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic wr_err_q, wr_err_d, rd_err_q, rd_err_d, push_ok, pop_ok;
    always_comb begin
        push_ok  = bus.wr & (~full_q | bus.rd);
        pop_ok   = bus.rd & ~empty_q;
        w_ptr_d  = w_ptr_q + (AW+1)'(push_ok);
        r_ptr_d  = r_ptr_q + (AW+1)'(pop_ok);
        count_d  = w_ptr_d - r_ptr_d;
        full_d   = (w_ptr_d[AW-1:0] == r_ptr_d[AW-1:0]) & (w_ptr_d[AW] != r_ptr_d[AW]);
        empty_d  = w_ptr_d == r_ptr_d;
        af_d     = count_d >= AF;
        ae_d     = count_d <= AE;
        wr_err_d = bus.wr & ~push_ok;
        rd_err_d = bus.rd & ~pop_ok;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    // r_addr looks one pop ahead so the registered RAM read shows the new head
    assign bus.we           = push_ok & reset_n;
    assign bus.w_addr       = w_ptr_q[AW-1:0];
    assign bus.r_addr       = r_ptr_d[AW-1:0];
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_err       = rd_err_q;
endmodule
